arbitro_memoria: RTL
====================

Name: arbitro_memoria

Overview:
- Sequences and shares one unified single-port memory between two requesters: instruction fetch (IF, read-only) and load/store (LS, read/write, word or byte).
- Sits between the datapath driven by UnidadControl and the memory.
- Performs the request/acknowledge handshake, byte-lane steering for byte accesses (LBU/SB), misalignment checks, and a bounded wait on memory acknowledge.

Parameters:
- AW, 32, address width in bits (data width fixed at 32).
- TIMEOUT_CYC, 255, max cycles mem_req may stay high without mem_ack before abort; 0 disables timeout.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  AW  fetch address; bits [1:0] ignored (forced 0)
- if_done  out  1  one-cycle pulse: if_rdata valid or if_err
- if_rdata  out  32  fetched instruction word
- if_err  out  1  valid with if_done: timeout
- ls_req  in  1  load/store request; held until ls_done
- ls_we  in  1  1 = store, 0 = load
- ls_width  in  1  1 = word, 0 = byte (same encoding as control unit width)
- ls_addr  in  AW  data address
- ls_wdata  in  32  store data (byte stores use [7:0])
- ls_done  out  1  one-cycle pulse: access finished
- ls_rdata  out  32  load data; byte loads zero-extended
- ls_err  out  1  valid with ls_done: misaligned word or timeout
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_be  out  4  byte enables
- mem_addr  out  AW  word-aligned address ([1:0] = 0)
- mem_wdata  out  32  write data
- mem_ack  in  1  memory completion, one cycle; mem_rdata valid same cycle
- mem_rdata  in  32  memory read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n = 0 at a clock edge): state IDLE. All outputs 0: mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_done, ls_done, if_err, ls_err, if_rdata, ls_rdata, busy. Timeout counter cleared. Reset mid-transaction abandons it silently; no done pulse.
- States: IDLE, SERV_IF, SERV_LS.
- IDLE, arbitration:
  - ls_req = 1 → SERV_LS, else if_req = 1 → SERV_IF. Fixed LS priority unless the optional feature is compiled in.
  - Request fields (address, we, width, wdata) are latched into mem_* registers on the transition edge.
- Misaligned LS word access (ls_width = 1 and ls_addr[1:0] != 0): detected in IDLE. No memory access; next cycle ls_done = 1 and ls_err = 1, ls_rdata = 0; remain IDLE.
- SERV_x:
  - mem_req = 1 is registered, so it asserts the cycle after the request is sampled.
  - On the cycle mem_ack = 1: capture rdata, drop mem_req, go IDLE.
  - x_done pulses on the following cycle with x_err = 0.
  - Minimum latency: request sampled at edge 0, mem_req high in cycle 1, ack in cycle 1, done in cycle 2.
- Byte accesses (ls_width = 0):
  - mem_be = 4'b0001 << ls_addr[1:0].
  - mem_wdata = {4{ls_wdata[7:0]}}.
  - ls_rdata = {24'b0, selected byte of mem_rdata}.
- Word accesses: mem_be = 4'b1111; fetch always uses mem_be = 4'b1111 and mem_we = 0.
- Timeout (TIMEOUT_CYC > 0):
  - Counter counts cycles with mem_req = 1 and mem_ack = 0.
  - On reaching TIMEOUT_CYC: drop mem_req, go IDLE, pulse x_done with x_err = 1, rdata = 0.
  - A mem_ack arriving in the same cycle as expiry wins (normal completion).
- Requester deasserting x_req mid-service: ignored; the transaction completes and done still pulses.
- Requester must deassert x_req in the done cycle; if still high, it is sampled as a new request in that cycle (IDLE).
- mem_ack while in IDLE: ignored.
- x_done and x_err never pulse for the non-served requester. if_done and ls_done are never high together.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: 1-bit last-served flag, cleared on reset. When both if_req and ls_req are high in IDLE, the requester not served last wins; single requests are served as normal.
- Undefined: fixed LS-over-IF priority; the flag is not implemented.

Test Plan:
- Fetch: if_req = 1, if_addr = 0x0000_0013, mem_ack one cycle after mem_req, mem_rdata = 0x0000_0033 → mem_addr = 0x10, mem_be = 4'hF, mem_we = 0, if_done pulse 2 cycles after request with if_rdata = 0x33, if_err = 0.
- LBU: ls_req = 1, ls_we = 0, ls_width = 0, ls_addr = 0x102, mem_rdata = 0xAABBCCDD → mem_be = 4'b0100, ls_rdata = 0x0000_00BB.
- SB then misaligned SW:
  - SB: ls_addr = 0x203, ls_wdata = 0x5A → mem_be = 4'b1000, mem_wdata = 0x5A5A5A5A, mem_we = 1.
  - SW: ls_addr = 0x202 → no mem_req, ls_done = 1 with ls_err = 1.
- Contention: if_req and ls_req both high in the same cycle for two back-to-back rounds → without macro, LS served both rounds first; with ARB_ROUND_ROBIN_EN, order LS, IF, LS, IF.
- Timeout: TIMEOUT_CYC = 4, mem_ack held 0 → mem_req high exactly 4 cycles, then ls_done = 1, ls_err = 1. Repeat with mem_ack at cycle 4 → normal done, ls_err = 0.
- Reset mid-transaction: rst_n = 0 while in SERV_IF with mem_req = 1 → next cycle all outputs 0, busy = 0, no if_done. After release, a fresh fetch completes normally.

Source files
------------

// File: rtl/arbitro_memoria.sv
// arbitro_memoria: shares one single-port 32-bit memory between instruction
// fetch (read-only) and load/store (word/byte) requesters. Handles the
// req/ack handshake, byte-lane steering, misaligned-word rejection and a
// bounded wait on mem_ack (TIMEOUT_CYC cycles, 0 = wait forever).
// Optional macro ARB_ROUND_ROBIN_EN: alternate between requesters on
// contention instead of fixed load/store priority.
module arbitro_memoria #(
  parameter int AW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [31:0]   if_rdata,
  output logic          if_err,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic          ls_width,
  input  logic [AW-1:0] ls_addr,
  input  logic [31:0]   ls_wdata,
  output logic          ls_done,
  output logic [31:0]   ls_rdata,
  output logic          ls_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, SERV_IF, SERV_LS} state_t;

  // Counter only needs to reach TIMEOUT_CYC-1 before expiry fires.
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

  state_t        state_q;
  logic          mem_req_q, mem_we_q;
  logic [3:0]    mem_be_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic          if_done_q, if_err_q, ls_done_q, ls_err_q;
  logic [31:0]   if_rdata_q, ls_rdata_q;
  logic [1:0]    lane_q;
  logic          word_q;
  logic [CW-1:0] cnt_q;
  logic          pick_ls;
  logic          to_hit;
  logic [7:0]    sel_byte;
  logic [31:0]   load_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic          last_ls_q;
  // On contention the requester that was not served last wins.
  assign pick_ls = ls_req && (!if_req || !last_ls_q);
`else
  assign pick_ls = ls_req;
`endif

  assign to_hit = (TIMEOUT_CYC != 0) && (cnt_q == CW'(TIMEOUT_CYC - 1));

  // Steer the addressed byte lane of the read word down to bits [7:0].
  always_comb begin
    sel_byte = mem_rdata[7:0];
    case (lane_q)
      2'd1:    sel_byte = mem_rdata[15:8];
      2'd2:    sel_byte = mem_rdata[23:16];
      2'd3:    sel_byte = mem_rdata[31:24];
      default: sel_byte = mem_rdata[7:0];
    endcase
  end

  assign load_data = word_q ? mem_rdata : {24'b0, sel_byte};

  // Arbitration FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      if_err_q    <= 1'b0;
      ls_done_q   <= 1'b0;
      ls_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      lane_q      <= '0;
      word_q      <= 1'b0;
      cnt_q       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_ls_q   <= 1'b0;
`endif
    end else begin
      if_done_q <= 1'b0;
      if_err_q  <= 1'b0;
      ls_done_q <= 1'b0;
      ls_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (pick_ls) begin
`ifdef ARB_ROUND_ROBIN_EN
            last_ls_q <= 1'b1;
`endif
            if (ls_width && (ls_addr[1:0] != 2'b00)) begin
              // Misaligned word: answer with an error, never touch memory.
              ls_done_q  <= 1'b1;
              ls_err_q   <= 1'b1;
              ls_rdata_q <= '0;
            end else begin
              state_q     <= SERV_LS;
              mem_req_q   <= 1'b1;
              mem_we_q    <= ls_we;
              mem_be_q    <= ls_width ? 4'hF : (4'b0001 << ls_addr[1:0]);
              mem_addr_q  <= ls_addr & ALIGN_MASK;
              mem_wdata_q <= ls_width ? ls_wdata : {4{ls_wdata[7:0]}};
              lane_q      <= ls_addr[1:0];
              word_q      <= ls_width;
            end
          end else if (if_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            last_ls_q <= 1'b0;
`endif
            state_q    <= SERV_IF;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_be_q   <= 4'hF;
            mem_addr_q <= if_addr & ALIGN_MASK;
            lane_q     <= 2'd0;
            word_q     <= 1'b1;
          end
        end
        SERV_IF, SERV_LS: begin
          if (mem_ack) begin
            // Ack wins even on the cycle the timeout would expire.
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            if (state_q == SERV_IF) begin
              if_done_q  <= 1'b1;
              if_rdata_q <= mem_rdata;
            end else begin
              ls_done_q  <= 1'b1;
              ls_rdata_q <= load_data;
            end
          end else if (to_hit) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            if (state_q == SERV_IF) begin
              if_done_q  <= 1'b1;
              if_err_q   <= 1'b1;
              if_rdata_q <= '0;
            end else begin
              ls_done_q  <= 1'b1;
              ls_err_q   <= 1'b1;
              ls_rdata_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign ls_done   = ls_done_q;
  assign ls_err    = ls_err_q;
  assign ls_rdata  = ls_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule
